speed_loop_pi: RTL and testbench

Parametrised speed-loop controller: decimates the current-loop enable strobe by a runtime ratio and runs a PI regulator on speed error. The regulator uses one shared multiplier, integrator anti-windup and an output current clamp. It sits between the encoder speed estimator and the current loop and produces the Iq reference once per N current-loop periods.

---
 rtl/speed_loop_pkg.sv | 40 ++++
 rtl/spd_tick_div.sv | 50 +++++
 rtl/speed_loop_pi.sv | 197 +++++++++++++++++++
 tb/tb_speed_loop_pi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_loop_pkg.sv
// Shared types, default widths and the saturation helper for the speed-loop
// PI controller.
package speed_loop_pkg;

  // Calculation sequencer states, one multiply per state
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    PMUL = 3'd2,
    IMUL = 3'd3,
    SUM  = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam int SPD_W_DEF     = 13;
  localparam int IQ_W_DEF      = 12;
  localparam int GAIN_W_DEF    = 16;
  localparam int GAIN_FRAC_DEF = 10;
  localparam int INT_W_DEF     = 32;
  localparam int DIV_W_DEF     = 8;

  // Clamp a signed value into [lo, hi]; callers sign-extend into 64 bits
  // and truncate the result back to their own width.
  function automatic logic signed [63:0] sat_s64(
    input logic signed [63:0] x,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    logic signed [63:0] r;
    if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/spd_tick_div.sv
// Rising-edge detector on the current-loop strobe followed by a runtime
// divide-by-N counter. oTrig is a combinational pulse in the cycle whose
// closing edge wraps the counter, so the sequencer leaves IDLE on that edge.
module spd_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSL_en,
  input  logic [DIV_W-1:0] iDiv,
  output logic             oTrig
);

  logic             r_en_d;
  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;
  logic             w_wrap;
  logic [DIV_W-1:0] w_last;

  // Edge detect and wrap compare; N=0 behaves as N=1 and a count already
  // beyond a newly lowered N-1 wraps on the next tick
  always_comb begin
    w_tick = iSL_en & ~r_en_d;
    if (iDiv == {DIV_W{1'b0}}) begin
      w_last = {DIV_W{1'b0}};
    end else begin
      w_last = iDiv - {{(DIV_W-1){1'b0}}, 1'b1};
    end
    w_wrap = (r_cnt >= w_last);
    oTrig  = w_tick & w_wrap;
  end

  // Strobe history and tick counter
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_en_d <= 1'b0;
      r_cnt  <= {DIV_W{1'b0}};
    end else begin
      r_en_d <= iSL_en;
      if (w_tick) begin
        if (w_wrap) begin
          r_cnt <= {DIV_W{1'b0}};
        end else begin
          r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/speed_loop_pi.sv
// Speed-loop PI regulator: decimated trigger, one shared multiplier,
// saturating integrator with anti-windup and a symmetric output clamp.
// Optional feature macro SPD_LOOP_RAMP_EN adds iRamp_step and a rate-limited
// effective setpoint register.
module speed_loop_pi
  import speed_loop_pkg::*;
#(
  parameter int SPD_W     = SPD_W_DEF,
  parameter int IQ_W      = IQ_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int INT_W     = INT_W_DEF,
  parameter int DIV_W     = DIV_W_DEF
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iSL_en,
  input  logic [DIV_W-1:0]         iDiv,
  input  logic signed [SPD_W-1:0]  iSpd_set,
  input  logic signed [SPD_W-1:0]  iSpd_coder,
  input  logic signed [GAIN_W-1:0] iKp,
  input  logic signed [GAIN_W-1:0] iKi,
  input  logic [IQ_W-2:0]          iIq_max,
`ifdef SPD_LOOP_RAMP_EN
  input  logic [SPD_W-2:0]         iRamp_step,
`endif
  input  logic                     iInt_clr,
  output logic signed [IQ_W-1:0]   oIq,
  output logic                     oSL_done,
  output logic                     oSat,
  output logic                     oOvr,
  output logic                     oBusy
);

  localparam int E_W = SPD_W + 1;
  localparam int P_W = GAIN_W + E_W;
  localparam int S_W = ((P_W > INT_W) ? P_W : INT_W) + 1;
  localparam logic signed [63:0] L_INT_MAX = (64'sd1 <<< (INT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] L_INT_MIN = -(64'sd1 <<< (INT_W - 1));

  state_t                  r_state, w_next;
  logic                    w_trig;
  logic signed [SPD_W-1:0] w_set_eff;
  logic signed [E_W-1:0]   w_e, r_e;
  logic signed [GAIN_W-1:0] w_gain;
  logic signed [P_W-1:0]   w_prod, r_p, r_q;
  logic signed [INT_W-1:0] r_int, w_int_sat, w_int_next;
  logic signed [S_W-1:0]   w_sum, r_s;
  logic signed [63:0]      w_u, w_max, w_u_clamp;
  logic signed [IQ_W-1:0]  r_iq;
  logic r_sat, r_done, r_ovr, r_busy;
  logic w_freeze, w_e_pos, w_e_neg, w_iq_pos, w_iq_neg;

  spd_tick_div #(.DIV_W(DIV_W)) u_div (
    .iClk   (iClk),
    .iRst   (iRst),
    .iSL_en (iSL_en),
    .iDiv   (iDiv),
    .oTrig  (w_trig)
  );

`ifdef SPD_LOOP_RAMP_EN
  logic signed [SPD_W-1:0] r_set_eff;
  logic signed [SPD_W:0]   w_diff, w_step;

  // Move the effective setpoint toward iSpd_set by at most one step
  always_comb begin
    w_diff = {iSpd_set[SPD_W-1], iSpd_set} - {r_set_eff[SPD_W-1], r_set_eff};
    w_step = {2'b00, iRamp_step};
    if (w_diff > w_step) begin
      w_set_eff = r_set_eff + w_step[SPD_W-1:0];
    end else if (w_diff < -w_step) begin
      w_set_eff = r_set_eff - w_step[SPD_W-1:0];
    end else begin
      w_set_eff = iSpd_set;
    end
  end

  // Effective setpoint advances only when an error sample is taken
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_set_eff <= '0;
    end else if (r_state == ERR) begin
      r_set_eff <= w_set_eff;
    end else begin
      r_set_eff <= r_set_eff;
    end
  end
`else
  // Without ramping the setpoint is used directly
  always_comb begin
    w_set_eff = iSpd_set;
  end
`endif

  // Sequencer state register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: a fixed five-step walk once triggered
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_next = ERR;
        end else begin
          w_next = IDLE;
        end
      end
      ERR:     w_next = PMUL;
      PMUL:    w_next = IMUL;
      IMUL:    w_next = SUM;
      SUM:     w_next = OUT;
      OUT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: error, shared product, anti-windup integrator, shift and clamp
  always_comb begin
    w_e = {w_set_eff[SPD_W-1], w_set_eff} - {iSpd_coder[SPD_W-1], iSpd_coder};
    if (r_state == PMUL) begin
      w_gain = iKp;
    end else begin
      w_gain = iKi;
    end
    w_prod = P_W'(w_gain) * P_W'(r_e);

    // Freeze when the previous result was clamped and e pushes further out
    w_e_pos  = ~r_e[E_W-1] & (|r_e);
    w_e_neg  = r_e[E_W-1];
    w_iq_pos = ~r_iq[IQ_W-1] & (|r_iq);
    w_iq_neg = r_iq[IQ_W-1];
    w_freeze = r_sat & ((w_e_pos & w_iq_pos) | (w_e_neg & w_iq_neg));

    w_int_sat = INT_W'(sat_s64(64'(r_int) + 64'(r_q), L_INT_MIN, L_INT_MAX));
    if (iInt_clr) begin
      w_int_next = '0;
    end else if ((r_state == SUM) && !w_freeze) begin
      w_int_next = w_int_sat;
    end else begin
      w_int_next = r_int;
    end

    w_sum     = S_W'(w_int_next) + S_W'(r_p);
    w_u       = 64'(r_s) >>> GAIN_FRAC;
    w_max     = {{(65-IQ_W){1'b0}}, iIq_max};
    w_u_clamp = sat_s64(w_u, -w_max, w_max);
  end

  // Pipeline registers and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_e    <= '0;
      r_p    <= '0;
      r_q    <= '0;
      r_s    <= '0;
      r_int  <= '0;
      r_iq   <= '0;
      r_sat  <= 1'b0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= w_trig & (r_state != IDLE);
      r_busy <= (w_next != IDLE);
      r_int  <= w_int_next;
      case (r_state)
        ERR:  r_e <= w_e;
        PMUL: r_p <= w_prod;
        IMUL: r_q <= w_prod;
        SUM:  r_s <= w_sum;
        OUT: begin
          r_iq   <= w_u_clamp[IQ_W-1:0];
          r_sat  <= (w_u_clamp != w_u);
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign oIq      = r_iq;
  assign oSL_done = r_done;
  assign oSat     = r_sat;
  assign oOvr     = r_ovr;
  assign oBusy    = r_busy;

endmodule

// File: tb/tb_speed_loop_pi.sv
// Scoreboard bench for speed_loop_pi: a behavioural model predicts each
// calculation at trigger time and a negedge monitor checks every oSL_done.
module tb_speed_loop_pi;

  localparam int SPD_W = 13, IQ_W = 12, GAIN_W = 16, GAIN_FRAC = 10, INT_W = 32, DIV_W = 8;

  logic clk = 1'b0;
  logic rst, sl_en, int_clr;
  logic [DIV_W-1:0] div;
  logic signed [SPD_W-1:0] set, coder;
  logic signed [GAIN_W-1:0] kp, ki;
  logic [IQ_W-2:0] iq_max;
`ifdef SPD_LOOP_RAMP_EN
  logic [SPD_W-2:0] ramp_step;
`endif
  logic signed [IQ_W-1:0] iq;
  logic done, sat, ovr, busy;

  speed_loop_pi #(.SPD_W(SPD_W), .IQ_W(IQ_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC),
                  .INT_W(INT_W), .DIV_W(DIV_W)) dut (
    .iClk(clk), .iRst(rst), .iSL_en(sl_en), .iDiv(div),
    .iSpd_set(set), .iSpd_coder(coder), .iKp(kp), .iKi(ki), .iIq_max(iq_max),
`ifdef SPD_LOOP_RAMP_EN
    .iRamp_step(ramp_step),
`endif
    .iInt_clr(int_clr), .oIq(iq), .oSL_done(done), .oSat(sat), .oOvr(ovr), .oBusy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; longint iq; bit sat; } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_pass = 0;
  int ovr_seen = 0, done_seen = 0;

  // reference model state
  int m_cnt, m_lastT, m_ovr_exp = 0;
  longint m_I, m_iq, m_set_eff;
  bit m_sat;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint clamp(longint x, longint lo, longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_I = 0; m_iq = 0; m_sat = 0; m_set_eff = 0; m_lastT = -100;
  endtask

  // One calculation as the specification describes it, on plain integers
  task automatic model_trigger(int T);
    longint e, p, q, s, u, uc, mx, st, lim;
    bit frz;
    if (T <= m_lastT + 5) begin
      m_ovr_exp++;
      return;
    end
    m_lastT = T;
    st = 0;
`ifdef SPD_LOOP_RAMP_EN
    st = longint'(ramp_step);
    if (longint'(set) - m_set_eff > st) m_set_eff = m_set_eff + st;
    else if (longint'(set) - m_set_eff < -st) m_set_eff = m_set_eff - st;
    else m_set_eff = longint'(set);
`else
    m_set_eff = longint'(set) + st;
`endif
    e = m_set_eff - longint'(coder);
    p = longint'(kp) * e;
    q = longint'(ki) * e;
    frz = m_sat && ((e > 0 && m_iq > 0) || (e < 0 && m_iq < 0));
    lim = 64'sd1 <<< (INT_W - 1);
    if (!frz) m_I = clamp(m_I + q, -lim, lim - 1);
    s = p + m_I;
    u = s >>> GAIN_FRAC;
    mx = longint'(iq_max);
    uc = clamp(u, -mx, mx);
    m_sat = (uc != u);
    m_iq = uc;
    sb.push_back('{T + 5, uc, m_sat});
  endtask

  // One strobe pulse; the model sees the tick at the edge it is sampled on
  task automatic tick();
    int T, n;
    @(negedge clk); sl_en = 1'b1;
    @(negedge clk); sl_en = 1'b0; T = cyc;
    n = (div == 0) ? 1 : int'(div);
    if (m_cnt >= n - 1) begin
      m_cnt = 0;
      model_trigger(T);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk); int_clr = 1'b1;
    @(negedge clk); int_clr = 1'b0;
    m_I = 0;
  endtask

  task automatic wait_idle();
    while (cyc < m_lastT + 6) @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: every result pulse must match the oldest prediction
  always @(negedge clk) begin
    exp_t x;
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        x = sb.pop_front();
        check("done_cycle", cyc, x.t);
        check("iq", iq, x.iq);
        check("sat", sat, x.sat);
      end
    end
    if (ovr) ovr_seen++;
  end

  initial begin
    int d0;
    rst = 1'b1; sl_en = 1'b0; int_clr = 1'b0; div = 8'd1;
    set = '0; coder = '0; kp = '0; ki = '0; iq_max = 11'd2047;
`ifdef SPD_LOOP_RAMP_EN
    ramp_step = 12'd4095;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_iq", iq, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 0);

    // proportional step with busy window
    kp = 16'sd1024; ki = 16'sd0; set = 13'sd100; coder = 13'sd40; iq_max = 11'd2047;
    tick();
    check("busy_first", busy, 1);
    repeat (4) @(negedge clk);
    check("busy_last", busy, 1);
    @(negedge clk);
    check("busy_clear", busy, 0);
    wait_idle();
    check("p_step_iq", iq, 60);

    // decimation by 10, then N=0
    div = 8'd10; d0 = done_seen;
    for (int i = 0; i < 25; i++) begin
      tick();
      repeat (18) @(negedge clk);
    end
    wait_idle();
    check("div10_pulses", done_seen - d0, 2);
    div = 8'd0; d0 = done_seen;
    for (int i = 0; i < 3; i++) begin
      tick();
      repeat (8) @(negedge clk);
    end
    wait_idle();
    check("div0_pulses", done_seen - d0, 3);

    // integrator and clear
    kp = 16'sd0; ki = 16'sd1024; set = 13'sd5; coder = 13'sd0; div = 8'd1;
    clr_pulse();
    for (int i = 1; i <= 3; i++) begin
      tick(); wait_idle();
      check("int_iq", iq, 5 * i);
    end
    clr_pulse();
    tick(); wait_idle();
    check("int_after_clr", iq, 5);

    // saturation and anti-windup
    kp = 16'sd1024; ki = 16'sd512; set = 13'sd4000; coder = 13'sd0;
    clr_pulse();
    tick(); wait_idle();
    check("sat_iq", iq, 2047);
    check("sat_flag", sat, 1);
    check("sat_int", dut.r_int, 2048000);
    for (int i = 0; i < 3; i++) begin
      tick(); wait_idle();
      check("sat_int_hold", dut.r_int, 2048000);
    end

    // overrun: second tick three cycles after the first
    ki = 16'sd0; set = 13'sd100; coder = 13'sd40;
    clr_pulse();
    d0 = ovr_seen;
    tick();
    @(negedge clk);
    tick();
    wait_idle();
    check("ovr_pulses", ovr_seen - d0, 1);

    // reset mid-calculation with the divider mid-count
    div = 8'd2;
    tick(); repeat (3) @(negedge clk);
    tick();
    @(negedge clk); sl_en = 1'b1; m_cnt = 1;
    @(negedge clk); sl_en = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
    model_reset();
    repeat (10) @(negedge clk);
    check("abort_iq", iq, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", dut.u_div.r_cnt, 0);

    // randomized traffic, inputs changed only between calculations
    for (int i = 0; i < 150; i++) begin
      if (cyc >= m_lastT + 5) begin
        set = SPD_W'(int'($urandom_range(0, 8190)) - 4095);
        coder = SPD_W'(int'($urandom_range(0, 8190)) - 4095);
        kp = GAIN_W'(int'($urandom_range(0, 4096)) - 2048);
        ki = GAIN_W'(int'($urandom_range(0, 4096)) - 2048);
        iq_max = (IQ_W-1)'($urandom_range(0, 2047));
        if ($urandom_range(0, 5) == 0) clr_pulse();
      end
      div = DIV_W'($urandom_range(0, 3));
      tick();
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    wait_idle();

`ifdef SPD_LOOP_RAMP_EN
    // ramped setpoint: settle effective setpoint at 0, then ramp to 100
    div = 8'd1; kp = 16'sd1024; ki = 16'sd0; coder = 13'sd0; iq_max = 11'd2047;
    set = 13'sd0; ramp_step = 12'd4095;
    clr_pulse();
    tick(); wait_idle();
    set = 13'sd100; ramp_step = 12'd10;
    for (int k = 1; k <= 12; k++) begin
      tick(); wait_idle();
      check("ramp_iq", iq, (k * 10 > 100) ? 100 : k * 10);
    end
`endif

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("ovr_total", ovr_seen, m_ovr_exp);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
